// File: rtl/spi_packet_tx.sv
//============================================================================
// Module      : spi_packet_tx
// Description : Single-lane SPI master (mode 0) that pulls 32-bit words from
//               an upstream packet generator over a valid/ready handshake and
//               shifts them out MSB-first with cs_n held low for the packet.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters:
//   CLK_DIV       sclk half-period in clk cycles (1..255)
//   CS_SETUP      clk cycles from cs_n falling to the first word fetch (>=1)
//   CS_HOLD       clk cycles from last sclk falling edge to cs_n rising (>=1)
//   TIMEOUT_LIMIT max clk cycles spent in LOAD waiting for data_in_valid
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, length     packet start pulse and byte length (multiple of 4, >0)
//   data_in, data_in_valid, data_in_ready   upstream word handshake
//   sending           packet in progress (cs_n low)
//   sclk, cs_n, mosi  SPI outputs; miso SPI input
//   rx_data, rx_valid received word and its one-cycle valid pulse
//   done, error       one-cycle completion / fault pulses
// Optional feature macro:
//   SPI_PACKET_TX_RX_CAPTURE_EN  capture miso on sclk rising edges into
//                                rx_data; when undefined rx outputs are 0.
//============================================================================
`default_nettype none

module spi_packet_tx #(
    parameter int          CLK_DIV       = 4,
    parameter int          CS_SETUP      = 2,
    parameter int          CS_HOLD       = 2,
    parameter logic [15:0] TIMEOUT_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] length,
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    output logic        sending,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [7:0]  c_div_last   = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_setup_last = 16'(CS_SETUP - 1);
    localparam logic [15:0] c_hold_last  = 16'(CS_HOLD - 1);
    localparam logic [15:0] c_tmo_last   = TIMEOUT_LIMIT - 16'd1;

    state_t      r_state;
    state_t      w_next;

    logic [30:0] r_words_left;
    logic [31:0] r_shift;
    logic [7:0]  r_div_cnt;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_phase_cnt;
    logic [15:0] r_tmo_cnt;

    logic        w_len_ok;
    logic        w_accept;
    logic        w_reject;
    logic        w_handshake;
    logic        w_timeout;
    logic        w_div_tc;
    logic        w_fall;
    logic        w_word_end;
    logic        w_setup_end;
    logic        w_hold_end;

    // Outputs decoded from the state register only.
    assign cs_n          = (r_state == S_IDLE);
    assign sending       = (r_state != S_IDLE);
    assign data_in_ready = (r_state == S_LOAD);

    assign w_len_ok    = (length != 32'd0) && (length[1:0] == 2'b00);
    assign w_accept    = (r_state == S_IDLE) && start && w_len_ok;
    assign w_reject    = (r_state == S_IDLE) && start && !w_len_ok;
    assign w_handshake = (r_state == S_LOAD) && data_in_valid;
    // A handshake in the final allowed cycle wins over the timeout.
    assign w_timeout   = (r_state == S_LOAD) && !data_in_valid && (r_tmo_cnt == c_tmo_last);
    assign w_div_tc    = (r_div_cnt == c_div_last);
    assign w_fall      = (r_state == S_SHIFT) && w_div_tc && sclk;
    assign w_word_end  = w_fall && (r_bit_cnt == 5'd31);
    assign w_setup_end = (r_state == S_SETUP) && (r_phase_cnt == c_setup_last);
    assign w_hold_end  = (r_state == S_HOLD) && (r_phase_cnt == c_hold_last);

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SETUP;
            S_SETUP: if (w_setup_end) w_next = S_LOAD;
            S_LOAD: begin
                if (w_handshake) begin
                    w_next = S_SHIFT;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_word_end) begin
                    // words_left was already decremented at the handshake.
                    w_next = (r_words_left != 31'd0) ? S_LOAD : S_HOLD;
                end
            end
            S_HOLD:  if (w_hold_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath: counters, shift register, SPI pins, pulses
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_words_left <= '0;
            r_shift      <= '0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_phase_cnt  <= '0;
            r_tmo_cnt    <= '0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            done  <= w_hold_end;
            error <= w_reject || w_timeout;

            // Shared SETUP/HOLD counter restarts on every state change.
            if ((r_state == w_next) && ((r_state == S_SETUP) || (r_state == S_HOLD))) begin
                r_phase_cnt <= r_phase_cnt + 16'd1;
            end else begin
                r_phase_cnt <= '0;
            end

            if ((r_state == S_LOAD) && !w_handshake && !w_timeout) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= '0;
            end

            if (w_accept) begin
                r_words_left <= length[31:2];
            end

            if (w_handshake) begin
                r_shift      <= data_in;
                mosi         <= data_in[31];
                r_words_left <= r_words_left - 31'd1;
                r_div_cnt    <= '0;
                r_bit_cnt    <= '0;
                sclk         <= 1'b0;
            end else if (r_state == S_SHIFT) begin
                if (w_div_tc) begin
                    r_div_cnt <= '0;
                    sclk      <= ~sclk;
                    if (sclk) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_shift   <= {r_shift[30:0], 1'b0};
                        // Last bit stays on mosi through the inter-word gap.
                        if (r_bit_cnt != 5'd31) begin
                            mosi <= r_shift[30];
                        end
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end

            if ((r_state != S_IDLE) && (w_next == S_IDLE)) begin
                mosi <= 1'b0;
            end
        end
    end

`ifdef SPI_PACKET_TX_RX_CAPTURE_EN
    logic [31:0] r_rx_shift;
    logic        w_rise;

    assign w_rise = (r_state == S_SHIFT) && w_div_tc && !sclk;

    // On the k-th rising edge of a word r_bit_cnt equals k-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_shift <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (w_rise) begin
                r_rx_shift <= {r_rx_shift[30:0], miso};
                if (r_bit_cnt == 5'd31) begin
                    rx_data  <= {r_rx_shift[30:0], miso};
                    rx_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic w_unused_miso;

    assign w_unused_miso = miso;
    assign rx_data       = '0;
    assign rx_valid      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_packet_tx.sv
//============================================================================
// Module      : tb_spi_packet_tx
// Description : Directed self-checking bench for spi_packet_tx
//               (CLK_DIV=4, CS_SETUP=2, CS_HOLD=2, TIMEOUT_LIMIT=16).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_spi_packet_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] length;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        sending;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (written only by the monitor process)
    int          rise_cnt   = 0;
    int          cs_low_cnt = 0;
    int          done_cnt   = 0;
    int          err_cnt    = 0;
    int          gap_bad    = 0;
    int          rxv_cnt    = 0;
    logic [63:0] cap_bits   = '0;
    logic        prev_sclk  = 1'b0;

    spi_packet_tx #(
        .CLK_DIV      (4),
        .CS_SETUP     (2),
        .CS_HOLD      (2),
        .TIMEOUT_LIMIT(16'd16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .length       (length),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .sending      (sending),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .done         (done),
        .error        (error)
    );

    assign miso = mosi;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        prev_sclk <= sclk;
        if (sclk && !prev_sclk) begin
            rise_cnt <= rise_cnt + 1;
            cap_bits <= {cap_bits[62:0], mosi};
        end
        if (!cs_n)   cs_low_cnt <= cs_low_cnt + 1;
        if (done)    done_cnt   <= done_cnt + 1;
        if (error)   err_cnt    <= err_cnt + 1;
        if (rx_valid) rxv_cnt   <= rxv_cnt + 1;
        if (data_in_ready && (sclk || cs_n)) gap_bad <= gap_bad + 1;
        if (sending == cs_n) gap_bad <= gap_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] len);
        length = len;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int t;
        t = 0;
        while (!data_in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            check("ready_wait", 64'(0), 64'(1));
        end else begin
            repeat (gap) @(negedge clk);
            data_in       = w;
            data_in_valid = 1'b1;
            @(negedge clk);
            data_in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("done_wait", 64'(0), 64'(1));
        // let the monitor absorb the final cycles
        repeat (4) @(negedge clk);
    endtask

    task automatic run_two_words(input int gap, input string tag);
        int r0, c0, d0, e0, g0;
        r0 = rise_cnt; c0 = cs_low_cnt; d0 = done_cnt; e0 = err_cnt; g0 = gap_bad;
        pulse_start(32'd8);
        check({tag, "_cs_low_after_start"}, 64'(cs_n), 64'(0));
        send_word(32'hA5A5A5A5, gap);
        send_word(32'h0F0F0F0F, gap);
        wait_done();
        check({tag, "_bits"},       cap_bits, 64'hA5A5A5A5_0F0F0F0F);
        check({tag, "_rises"},      64'(rise_cnt - r0), 64'(64));
        check({tag, "_cs_low_cyc"}, 64'(cs_low_cnt - c0), 64'(518 + 2 * gap));
        check({tag, "_done_cnt"},   64'(done_cnt - d0), 64'(1));
        check({tag, "_err_cnt"},    64'(err_cnt - e0), 64'(0));
        check({tag, "_gap_pins"},   64'(gap_bad - g0), 64'(0));
    endtask

    initial begin
        int t, d0, e0, x0;

        rst = 1'b1; start = 1'b0; length = '0; data_in = '0; data_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs_n",    64'(cs_n), 64'(1));
        check("rst_sclk",    64'(sclk), 64'(0));
        check("rst_mosi",    64'(mosi), 64'(0));
        check("rst_sending", 64'(sending), 64'(0));
        check("rst_ready",   64'(data_in_ready), 64'(0));
        check("rst_done",    64'(done), 64'(0));
        check("rst_error",   64'(error), 64'(0));
        check("rst_rx_data", 64'(rx_data), 64'(0));
        check("rst_rx_valid", 64'(rx_valid), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back words, then the same words with a 10-cycle upstream gap
        run_two_words(0, "nogap");
        run_two_words(10, "gap10");

        // Invalid lengths: error one cycle after start, no activity
        pulse_start(32'd6);
        check("len6_error",   64'(error), 64'(1));
        check("len6_cs_n",    64'(cs_n), 64'(1));
        check("len6_sending", 64'(sending), 64'(0));
        @(negedge clk);
        check("len6_err_pulse", 64'(error), 64'(0));
        pulse_start(32'd0);
        check("len0_error",   64'(error), 64'(1));
        check("len0_cs_n",    64'(cs_n), 64'(1));
        @(negedge clk);
        check("len0_err_pulse", 64'(error), 64'(0));
        check("len0_sending", 64'(sending), 64'(0));

        // LOAD timeout: upstream never valid
        d0 = done_cnt;
        pulse_start(32'd4);
        t = 0;
        while (!data_in_ready && t < 100) begin @(negedge clk); t++; end
        t = 0;
        while (!error && t < 100) begin @(negedge clk); t++; end
        check("tmo_cycles",  64'(t), 64'(16));
        check("tmo_cs_n",    64'(cs_n), 64'(1));
        check("tmo_sending", 64'(sending), 64'(0));
        check("tmo_ready",   64'(data_in_ready), 64'(0));
        @(negedge clk);
        check("tmo_err_pulse", 64'(error), 64'(0));
        repeat (3) @(negedge clk);
        check("tmo_no_done", 64'(done_cnt - d0), 64'(0));

        // Reset in the middle of word 1
        d0 = done_cnt; e0 = err_cnt; x0 = rxv_cnt;
        pulse_start(32'd8);
        send_word(32'hA5A5A5A5, 0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs_n",    64'(cs_n), 64'(1));
        check("abort_sclk",    64'(sclk), 64'(0));
        check("abort_sending", 64'(sending), 64'(0));
        check("abort_mosi",    64'(mosi), 64'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_pulse", 64'(done_cnt - d0 + err_cnt - e0), 64'(0));
        check("abort_no_rxv",   64'(rxv_cnt - x0), 64'(0));

        // Fresh single-word packet after the abort, miso looped to mosi
        d0 = done_cnt; t = rise_cnt;
        pulse_start(32'd4);
        send_word(32'h12345678, 0);
        wait_done();
        check("fresh_bits",  64'(cap_bits[31:0]), 64'h12345678);
        check("fresh_rises", 64'(rise_cnt - t), 64'(32));
        check("fresh_done",  64'(done_cnt - d0), 64'(1));
`ifdef SPI_PACKET_TX_RX_CAPTURE_EN
        check("rx_valid_cnt", 64'(rxv_cnt - x0), 64'(1));
        check("rx_data",      64'(rx_data), 64'h12345678);
`else
        check("rx_valid_cnt", 64'(rxv_cnt - x0), 64'(0));
        check("rx_data",      64'(rx_data), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
